// File: rtl/mop_pkg.sv
// Shared types and helpers for the multi-operand add sequencer.
//   state_t   : sequencer FSM states
//   mop_width : accumulator width that cannot overflow for k operands of n bits
`timescale 1ns/1ps
package mop_pkg;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int unsigned mop_width(input int unsigned n, input int unsigned k);
    return n + $clog2(k);
  endfunction

endpackage

// File: rtl/mop_wait_timer.sv
// Loadable down-counter that sequences the adder-latency wait.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : cycles remaining after the load edge
//   done_c     : combinational, high while the count is zero
`timescale 1ns/1ps
module mop_wait_timer
  import mop_pkg::*;
#(
  parameter  int unsigned ADD_LAT = 1,
  localparam int unsigned TW      = $clog2(ADD_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done_c
);

  logic [TW-1:0] count;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/mop_add_sequencer.sv
// Control unit for a shared clocked ripple-carry adder that serially sums a group
// of operands into a wide accumulator.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand stream handshake; in_data operand, in_last ends group
//   add_a/add_b/add_cin  : registered drive to the shared adder (accumulator, operand, 0)
//   add_s/add_cout       : adder result; carry-out is not needed since W cannot overflow
//   out_valid/out_ready  : group result handshake; out_sum sum, out_count operands summed
// Build option: define MOP_SIGNED_EN to treat operands as two's complement
// (sign-extended); otherwise operands are zero-extended.
`timescale 1ns/1ps
module mop_add_sequencer
  import mop_pkg::*;
#(
  parameter  int unsigned N       = 4,
  parameter  int unsigned K       = 8,
  parameter  int unsigned ADD_LAT = 1,
  localparam int unsigned W       = mop_width(N, K),
  localparam int unsigned CW      = $clog2(K + 1),
  localparam int unsigned TW      = $clog2(ADD_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic [W-1:0]  add_a,
  output logic [W-1:0]  add_b,
  output logic          add_cin,
  input  logic [W-1:0]  add_s,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [CW-1:0] out_count
);

  state_t        state, state_n;
  logic [W-1:0]  acc, acc_n;
  logic [W-1:0]  op_r, op_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] cnt_inc;
  logic          last_r, last_n;
  logic          tmr_load;
  logic          tmr_done_c;
  logic          unused_cout;

  // Extend an operand to accumulator width.
  function automatic logic [W-1:0] ext(input logic [N-1:0] d);
`ifdef MOP_SIGNED_EN
    return {{(W-N){d[N-1]}}, d};
`else
    return {{(W-N){1'b0}}, d};
`endif
  endfunction

  assign cnt_inc     = cnt + CW'(1);
  assign unused_cout = add_cout;

  // Adder operands come straight from the registers, so they are stable
  // from the cycle after an accept until the capture edge.
  assign add_a   = acc;
  assign add_b   = op_r;
  assign add_cin = 1'b0;

  mop_wait_timer #(
    .ADD_LAT (ADD_LAT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TW'(ADD_LAT - 1)),
    .done_c   (tmr_done_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    op_n     = op_r;
    last_n   = last_r;
    tmr_load = 1'b0;
    case (state)
      ACCEPT: begin
        if (in_valid) begin
          op_n     = ext(in_data);
          last_n   = in_last;
          tmr_load = 1'b1;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (tmr_done_c) begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        acc_n = add_s;
        cnt_n = cnt_inc;
        // Close the group on in_last or when it reaches K operands.
        if (last_r || (cnt_inc == CW'(K))) begin
          state_n = DONE;
        end else begin
          state_n = ACCEPT;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_n   = '0;
          cnt_n   = '0;
          state_n = ACCEPT;
        end
      end
      default: begin
        state_n = ACCEPT;
      end
    endcase
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCEPT;
      acc       <= '0;
      cnt       <= '0;
      op_r      <= '0;
      last_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      op_r      <= op_n;
      last_r    <= last_n;
      in_ready  <= (state_n == ACCEPT);
      out_valid <= (state_n == DONE);
      out_sum   <= (state_n == DONE) ? acc_n : '0;
      out_count <= (state_n == DONE) ? cnt_n : '0;
    end
  end

endmodule

// File: tb/tb_mop_add_sequencer.sv
// Scoreboard bench for mop_add_sequencer (N=4, K=4, ADD_LAT=1, W=6) with a
// registered adder model in place of the shared ripple adder.
`timescale 1ns/1ps
module tb_mop_add_sequencer;

  localparam int unsigned N       = 4;
  localparam int unsigned K       = 4;
  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned W       = 6;
  localparam int unsigned CW      = 3;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic [CW-1:0] count;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic [W-1:0]  add_a, add_b, add_s;
  logic          add_cin, add_cout;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t mon_e;

  mop_add_sequencer #(.N(N), .K(K), .ADD_LAT(ADD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared adder model: ADD_LAT register stages behind a plain add.
  logic [W:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {add_cout, add_s} = pipe[ADD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void push(input logic [W-1:0] s, input logic [CW-1:0] c);
    exp_t e;
    e.sum   = s;
    e.count = c;
    sb.push_back(e);
  endfunction

  // Monitor: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got sum %0d count %0d, want no output", out_sum, out_count);
      end else begin
        mon_e = sb.pop_front();
        chk("out_sum", 32'(out_sum), 32'(mon_e.sum));
        chk("out_count", 32'(out_count), 32'(mon_e.count));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [N-1:0] d, input logic l, output int acc_cyc);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc_cyc  = -1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (acc_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, want an accept");
    end
  endtask

  task automatic wait_valid(output int seen);
    seen = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    if (seen < 0) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got out_valid=0 for 100 cycles, want 1");
    end
  endtask

  initial begin
    int a0, t, v;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full group closed by in_last on the 4th operand: 3+5+7+15.
    push(6'd30, 3'd4);
    send(4'd3, 1'b0, a0);
    send(4'd5, 1'b0, t);
    send(4'd7, 1'b0, t);
    send(4'd15, 1'b1, t);
    wait_valid(v);
    // Edges from the first accept edge to the edge raising out_valid, both inclusive.
    chk("latency", 32'(v - a0 + 1), 32'(4 * (ADD_LAT + 2)));
    @(negedge clk);
    chk("in_ready_after_done", 32'(in_ready), 32'd1);

    // Auto-close at K, then a one-operand group from the 5th operand.
    push(6'd36, 3'd4);
    push(6'd9, 3'd1);
    for (int i = 0; i < 4; i++) send(4'd9, 1'b0, t);
    send(4'd9, 1'b1, t);
    wait_valid(v);
    @(negedge clk);

    // Single-operand group.
    push(6'd6, 3'd1);
    send(4'd6, 1'b1, t);
    wait_valid(v);
    @(negedge clk);

    // Back-pressure in DONE: outputs hold and no new operand is accepted.
    out_ready = 1'b0;
    push(6'd5, 3'd2);
    send(4'd2, 1'b0, t);
    send(4'd3, 1'b1, t);
    in_valid = 1'b1;
    in_data  = 4'd7;
    wait_valid(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_sum", 32'(out_sum), 32'd5);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-WAIT of the 2nd operand discards the partial group.
    send(4'd1, 1'b0, t);
    send(4'd2, 1'b0, t);
    chk("midwait_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_add_a", 32'(add_a), 32'd0);
    chk("post_rst_add_b", 32'(add_b), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    push(6'd3, 3'd2);
    send(4'd1, 1'b0, t);
    send(4'd2, 1'b1, t);
    wait_valid(v);
    @(negedge clk);

    // 4'hF, 4'hE, 4'h1: -1-2+1 = -2 signed, 15+14+1 = 30 unsigned.
`ifdef MOP_SIGNED_EN
    push(6'h3E, 3'd3);
`else
    push(6'd30, 3'd3);
`endif
    send(4'hF, 1'b0, t);
    send(4'hE, 1'b0, t);
    send(4'h1, 1'b1, t);
    wait_valid(v);
    @(negedge clk);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
